// File: rtl/varredura_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
package varredura_display_pkg;

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    MOSTRA    = 2'd1,
    APAGA     = 2'd2
  } estado_t;

  localparam logic [7:0] OFF_SEG_AC = 8'hFF;
  localparam logic [7:0] OFF_SEG_CC = 8'h00;

endpackage

// File: rtl/varredura_display_decoder.sv
// BCD/hex to 7-segment decoder, bits 0..6 = a..g; polarity set by TIPO.
module encapsula_decoder #(
  parameter TIPO = "AC"
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  localparam bit EH_CC = (TIPO == "CC");

  logic [6:0] padrao;

  // Active-high pattern (gfedcba); codes 10..15 show A,b,C,d,E,F.
  always_comb begin
    padrao = '0;
    case (bcd)
      4'h0: padrao = 7'h3F;
      4'h1: padrao = 7'h06;
      4'h2: padrao = 7'h5B;
      4'h3: padrao = 7'h4F;
      4'h4: padrao = 7'h66;
      4'h5: padrao = 7'h6D;
      4'h6: padrao = 7'h7D;
      4'h7: padrao = 7'h07;
      4'h8: padrao = 7'h7F;
      4'h9: padrao = 7'h6F;
      4'hA: padrao = 7'h77;
      4'hB: padrao = 7'h7C;
      4'hC: padrao = 7'h39;
      4'hD: padrao = 7'h5E;
      4'hE: padrao = 7'h79;
      default: padrao = 7'h71;
    endcase
    seg = EH_CC ? padrao : ~padrao;
  end

endmodule

// File: rtl/varredura_display.sv
// Time-multiplexed scanner for N_DIG 7-segment digits with per-slot dead time.
module varredura_display
  import varredura_display_pkg::*;
#(
  parameter       TIPO      = "AC",
  parameter int   N_DIG     = 6,
  parameter int   DIV       = 50000,
  parameter int   BLANK     = 500,
  parameter logic SEL_ATIVO = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               habilita,
  input  logic [4*N_DIG-1:0] digitos,
  input  logic [N_DIG-1:0]   pontos,
  input  logic [N_DIG-1:0]   apaga,
  output logic [7:0]         segmentos,
  output logic [N_DIG-1:0]   selecao,
  output logic [2:0]         indice
);

  localparam int              PW         = $clog2(DIV);
  localparam logic [PW-1:0]   FIM_MOSTRA = PW'(DIV - BLANK - 1);
  localparam logic [PW-1:0]   FIM_SLOT   = PW'(DIV - 1);
  localparam logic [2:0]      ULTIMO     = 3'(N_DIG - 1);
  localparam bit              EH_CC      = (TIPO == "CC");
  localparam bit              TIPO_OK    = (TIPO == "AC") || EH_CC;
  localparam logic [7:0]      OFF_SEG    = EH_CC ? OFF_SEG_CC : OFF_SEG_AC;
  localparam logic [N_DIG-1:0] SEL_OFF   = {N_DIG{~SEL_ATIVO}};

  estado_t          estado, estado_prox;
  logic [PW-1:0]    presc, presc_prox;
  logic [2:0]       indice_prox;
  logic             entrada;
  logic [3:0]       cod_lat, cod_in, cod_prox;
  logic             dp_lat, dp_in, dp_prox;
  logic             apg_lat, apg_in, apg_prox;
  logic [6:0]       seg7;
  logic [7:0]       seg_prox;
  logic [N_DIG-1:0] sel_prox;

  // Slot sequencing: MOSTRA for DIV-BLANK cycles, APAGA for BLANK, then next digit.
  always_comb begin
    estado_prox = estado;
    presc_prox  = presc;
    indice_prox = indice;
    entrada     = 1'b0;
    case (estado)
      DESLIGADO: begin
        if (habilita) begin
          estado_prox = MOSTRA;
          presc_prox  = '0;
          indice_prox = '0;
          entrada     = 1'b1;
        end
      end
      MOSTRA: begin
        presc_prox = presc + 1'b1;
        if (presc == FIM_MOSTRA) estado_prox = APAGA;
      end
      APAGA: begin
        if (presc == FIM_SLOT) begin
          estado_prox = MOSTRA;
          presc_prox  = '0;
          indice_prox = (indice == ULTIMO) ? '0 : indice + 3'd1;
          entrada     = 1'b1;
        end else begin
          presc_prox = presc + 1'b1;
        end
      end
      default: estado_prox = DESLIGADO;
    endcase
    if (!habilita) begin
      estado_prox = DESLIGADO;
      presc_prox  = '0;
      indice_prox = '0;
      entrada     = 1'b0;
    end
  end

  // Digit fields of the slot about to start; the decoder sees the fresh code on
  // the entry edge and the latched one afterwards, so segmentos stays registered.
  always_comb begin
    cod_in = '0;
    dp_in  = 1'b0;
    apg_in = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (indice_prox == 3'(i)) begin
        cod_in = digitos[4*i +: 4];
        dp_in  = pontos[i];
        apg_in = apaga[i];
      end
    end
    cod_prox = entrada ? cod_in : cod_lat;
    dp_prox  = entrada ? dp_in  : dp_lat;
    apg_prox = entrada ? apg_in : apg_lat;
  end

  encapsula_decoder #(.TIPO(TIPO)) u_decoder (
    .bcd (cod_prox),
    .seg (seg7)
  );

  // Next output values, derived from the next state so select and segments change together.
  always_comb begin
    seg_prox = OFF_SEG;
    sel_prox = SEL_OFF;
    if (estado_prox == MOSTRA) begin
      for (int unsigned i = 0; i < N_DIG; i++) begin
        if (indice_prox == 3'(i)) sel_prox[i] = SEL_ATIVO;
      end
      if (TIPO_OK && !apg_prox) seg_prox = {(EH_CC ? dp_prox : ~dp_prox), seg7};
    end
  end

  // State, prescaler, latches and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= DESLIGADO;
      presc     <= '0;
      indice    <= '0;
      cod_lat   <= '0;
      dp_lat    <= 1'b0;
      apg_lat   <= 1'b0;
      segmentos <= OFF_SEG;
      selecao   <= SEL_OFF;
    end else begin
      estado    <= estado_prox;
      presc     <= presc_prox;
      indice    <= indice_prox;
      cod_lat   <= cod_prox;
      dp_lat    <= dp_prox;
      apg_lat   <= apg_prox;
      segmentos <= seg_prox;
      selecao   <= sel_prox;
    end
  end

endmodule
